adc_serial_responder: RTL and testbench

//  Synthesizable responder for the ADC_CNV/ADC_SCK/ADC_SDI/ADC_SDO serial link, i.e. the converter end
//  of the interface driven by the LCMS2012 ADC state machine. It replaces the real ADC in

---
 rtl/adc_resp_pkg.sv | 14 +
 rtl/adc_serial_responder_if.sv | 12 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/adc_serial_responder.sv | 174 +++++++++++++++++
 tb/tb_adc_serial_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the ADC serial responder.
// The FSM states and the synchronizer depth are used by both the top and the edge detector.
package adc_resp_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    READY   = 2'd2,
    SHIFT   = 2'd3
  } state_t;

endpackage

// File: rtl/adc_serial_responder_if.sv
// Four-wire ADC link: the initiator drives CNV/SCK/SDI and the converter end drives SDO.
interface adc_serial_responder_if;

  logic ADC_CNV;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (output ADC_CNV, output ADC_SCK, output ADC_SDI, input ADC_SDO);
  modport slave  (input ADC_CNV, input ADC_SCK, input ADC_SDI, output ADC_SDO);

endinterface

// File: rtl/sync_edge_det.sv
// Brings one asynchronous pin into s_clk, then reports its level and single-cycle rise/fall.
module sync_edge_det
  import adc_resp_pkg::*;
(
  input  logic s_clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus the previous-level register used for edge detection.
  always_ff @(posedge s_clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~prev_r;
  assign fall  = ~level & prev_r;

endmodule

// File: rtl/adc_serial_responder.sv
// Converter end of the CNV/SCK/SDI/SDO link: models conversion time, serves a latched
// sample MSB-first on SDO and captures the initiator's config word from SDI.
module adc_serial_responder
  import adc_resp_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CFG_W       = 6,
  parameter int CONV_CYCLES = 70
) (
  input  logic                  s_clk,
  input  logic                  reset,
  adc_serial_responder_if.slave adc,
  input  logic [DATA_W-1:0]     sample_i,
  output logic                  busy_o,
  output logic [CFG_W-1:0]      cfg_o,
  output logic                  cfg_valid_o,
  output logic                  frame_done_o,
  output logic                  overrun_o
);

  localparam int CONV_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W     = $clog2(DATA_W + 1);
  localparam int CFG_CNT_W = $clog2(CFG_W + 1);
  localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYCLES - 1);

  logic cnv_level_s, cnv_rise_s, cnv_fall_unused_s;
  logic sck_level_unused_s, sck_rise_s, sck_fall_s;
  logic sdi_level_s, sdi_rise_unused_s, sdi_fall_unused_s;

  sync_edge_det u_cnv_sync (.s_clk(s_clk), .reset(reset), .async_in(adc.ADC_CNV),
                            .level(cnv_level_s), .rise(cnv_rise_s), .fall(cnv_fall_unused_s));
  sync_edge_det u_sck_sync (.s_clk(s_clk), .reset(reset), .async_in(adc.ADC_SCK),
                            .level(sck_level_unused_s), .rise(sck_rise_s), .fall(sck_fall_s));
  sync_edge_det u_sdi_sync (.s_clk(s_clk), .reset(reset), .async_in(adc.ADC_SDI),
                            .level(sdi_level_s), .rise(sdi_rise_unused_s), .fall(sdi_fall_unused_s));

  state_t                state_r, state_s;
  logic [CONV_W-1:0]     conv_cnt_r, conv_cnt_s;
  logic [BIT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic [CFG_CNT_W-1:0]  cfg_cnt_r, cfg_cnt_s;
  logic [DATA_W-1:0]     shift_r, shift_s;
  logic [CFG_W-1:0]      cfg_sr_r, cfg_sr_s;
  logic [CFG_W-1:0]      cfg_s;
  logic                  sdo_r, sdo_s;
  logic                  busy_s, cfg_valid_s, frame_done_s, overrun_s;

  // Next-state, datapath and output decode for the link FSM.
  always_comb begin
    state_s      = state_r;
    conv_cnt_s   = conv_cnt_r;
    bit_cnt_s    = bit_cnt_r;
    cfg_cnt_s    = cfg_cnt_r;
    shift_s      = shift_r;
    cfg_sr_s     = cfg_sr_r;
    cfg_s        = cfg_o;
    sdo_s        = sdo_r;
    busy_s       = busy_o;
    cfg_valid_s  = 1'b0;
    frame_done_s = 1'b0;
    overrun_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (cnv_rise_s) begin
          shift_s    = sample_i;
          conv_cnt_s = CONV_LOAD;
          busy_s     = 1'b1;
          state_s    = CONVERT;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        // Any link activity while converting is a protocol violation and is otherwise ignored.
        if (cnv_rise_s || sck_rise_s || sck_fall_s) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = 1'b0;
        end
        if (conv_cnt_r == CONV_W'(0)) begin
          busy_s  = 1'b0;
          state_s = READY;
        end else begin
          conv_cnt_s = conv_cnt_r - CONV_W'(1);
        end
      end
      READY: begin
        if (!cnv_level_s) begin
          sdo_s     = shift_r[DATA_W-1];
          bit_cnt_s = '0;
          cfg_cnt_s = '0;
          cfg_sr_s  = '0;
          state_s   = SHIFT;
        end else begin
          state_s = READY;
        end
      end
      SHIFT: begin
        if (cnv_rise_s) begin
          overrun_s  = 1'b1;
          shift_s    = sample_i;
          conv_cnt_s = CONV_LOAD;
          busy_s     = 1'b1;
          sdo_s      = 1'b0;
          state_s    = CONVERT;
        end else begin
          // Rise is handled before fall; they touch disjoint registers so both apply.
          if (sck_rise_s && (cfg_cnt_r < CFG_CNT_W'(CFG_W))) begin
            cfg_sr_s  = {cfg_sr_r[CFG_W-2:0], sdi_level_s};
            cfg_cnt_s = cfg_cnt_r + CFG_CNT_W'(1);
            if (cfg_cnt_r == CFG_CNT_W'(CFG_W - 1)) begin
              cfg_s       = cfg_sr_s;
              cfg_valid_s = 1'b1;
            end else begin
              cfg_valid_s = 1'b0;
            end
          end else begin
            cfg_valid_s = 1'b0;
          end
          if (sck_fall_s) begin
            shift_s   = {shift_r[DATA_W-2:0], 1'b0};
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
              sdo_s        = 1'b0;
              frame_done_s = 1'b1;
              state_s      = IDLE;
            end else begin
              sdo_s = shift_r[DATA_W-2];
            end
          end else begin
            frame_done_s = 1'b0;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge s_clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      conv_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      cfg_cnt_r    <= '0;
      shift_r      <= '0;
      cfg_sr_r     <= '0;
      sdo_r        <= 1'b0;
      busy_o       <= 1'b0;
      cfg_o        <= '0;
      cfg_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      state_r      <= state_s;
      conv_cnt_r   <= conv_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      cfg_cnt_r    <= cfg_cnt_s;
      shift_r      <= shift_s;
      cfg_sr_r     <= cfg_sr_s;
      sdo_r        <= sdo_s;
      busy_o       <= busy_s;
      cfg_o        <= cfg_s;
      cfg_valid_o  <= cfg_valid_s;
      frame_done_o <= frame_done_s;
      overrun_o    <= overrun_s;
    end
  end

  assign adc.ADC_SDO = sdo_r;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: 100 MHz s_clk, 10 MHz SCK, 70-cycle conversion.
module tb_adc_serial_responder;

  logic        s_clk;
  logic        reset;
  logic [15:0] sample_i;
  logic        busy_o;
  logic [5:0]  cfg_o;
  logic        cfg_valid_o;
  logic        frame_done_o;
  logic        overrun_o;

  adc_serial_responder_if adc_bus ();

  adc_serial_responder #(.DATA_W(16), .CFG_W(6), .CONV_CYCLES(70)) dut (
    .s_clk(s_clk), .reset(reset), .adc(adc_bus), .sample_i(sample_i),
    .busy_o(busy_o), .cfg_o(cfg_o), .cfg_valid_o(cfg_valid_o),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cnt, done_cnt, cfgv_cnt, ovr_cnt;
  logic [15:0] rd_word;

  initial begin
    s_clk = 1'b0;
    forever #5 s_clk = ~s_clk;
  end

  // Count cycles each pulse/level output is high, sampled 1 ns after the clock edge.
  always @(posedge s_clk) begin
    #1;
    if (!reset) begin
      if (busy_o)       busy_cnt++;
      if (frame_done_o) done_cnt++;
      if (cfg_valid_o)  cfgv_cnt++;
      if (overrun_o)    ovr_cnt++;
    end
  end

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; cfgv_cnt = 0; ovr_cnt = 0;
  endtask

  task automatic reset_dut();
    @(negedge s_clk);
    reset = 1'b1;
    #20;
    reset = 1'b0;
    #20;
  endtask

  task automatic cnv_pulse(input logic [15:0] smp);
    sample_i = smp;
    adc_bus.ADC_CNV = 1'b1;
    #100;
    adc_bus.ADC_CNV = 1'b0;
  endtask

  // SCK cycles first..first+n-1 of a frame; SDO is read just before each rise.
  task automatic sck_cycles(input int first, input int n, input logic [5:0] cfg);
    for (int i = first; i < first + n; i++) begin
      adc_bus.ADC_SDI = (i < 6) ? cfg[5 - i] : 1'b0;
      #50;
      rd_word = {rd_word[14:0], adc_bus.ADC_SDO};
      adc_bus.ADC_SCK = 1'b1;
      #50;
      adc_bus.ADC_SCK = 1'b0;
    end
    adc_bus.ADC_SDI = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] smp, input logic [5:0] cfg);
    @(negedge s_clk);
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(smp);
    #900;
    sck_cycles(0, 16, cfg);
    #100;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_i = 16'h0000;
    adc_bus.ADC_CNV = 1'b0; adc_bus.ADC_SCK = 1'b0; adc_bus.ADC_SDI = 1'b0;
    #23;
    reset = 1'b0;
    #20;
    n_cmp++; if (adc_bus.ADC_SDO !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b want 0", adc_bus.ADC_SDO); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (cfg_o !== 6'b000000) begin n_fail++; $display("FAIL reset_cfg: got %b want 000000", cfg_o); end
    n_cmp++; if ({cfg_valid_o, frame_done_o, overrun_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {cfg_valid_o, frame_done_o, overrun_o}); end
  endtask

  task automatic test_single_frame();
    run_frame(16'hA5C3, 6'b000000);
    n_cmp++; if (rd_word !== 16'hA5C3) begin n_fail++; $display("FAIL frame_data: got %h want a5c3", rd_word); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_cnt !== 70) begin n_fail++; $display("FAIL busy_len: got %0d want 70", busy_cnt); end
    n_cmp++; if (adc_bus.ADC_SDO !== 1'b0) begin n_fail++; $display("FAIL sdo_after_frame: got %b want 0", adc_bus.ADC_SDO); end
    n_cmp++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL frame_overrun: got %0d want 0", ovr_cnt); end
    n_cmp++; if (cfgv_cnt !== 1) begin n_fail++; $display("FAIL frame_cfg_valid: got %0d want 1", cfgv_cnt); end
  endtask

  task automatic test_cfg_capture();
    @(negedge s_clk);
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(16'hA5C3);
    #900;
    sck_cycles(0, 5, 6'b101101);
    n_cmp++; if (cfgv_cnt !== 0) begin n_fail++; $display("FAIL cfg_early_valid: got %0d want 0", cfgv_cnt); end
    sck_cycles(5, 1, 6'b101101);
    n_cmp++; if (cfgv_cnt !== 1 || cfg_o !== 6'b101101) begin
      n_fail++; $display("FAIL cfg_after_6th: got valid=%0d cfg=%b want 1/101101", cfgv_cnt, cfg_o); end
    sck_cycles(6, 10, 6'b101101);
    #100;
    n_cmp++; if (cfg_o !== 6'b101101) begin n_fail++; $display("FAIL cfg_value: got %b want 101101", cfg_o); end
    n_cmp++; if (cfgv_cnt !== 1) begin n_fail++; $display("FAIL cfg_valid_count: got %0d want 1", cfgv_cnt); end
    n_cmp++; if (rd_word !== 16'hA5C3) begin n_fail++; $display("FAIL cfg_frame_data: got %h want a5c3", rd_word); end
  endtask

  task automatic test_overrun_convert();
    @(negedge s_clk);
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(16'h1234);
    #100;
    cnv_pulse(16'hBEEF);
    #100;
    adc_bus.ADC_SCK = 1'b1;
    #50;
    adc_bus.ADC_SCK = 1'b0;
    #450;
    sck_cycles(0, 16, 6'b010011);
    #100;
    n_cmp++; if (ovr_cnt !== 3) begin n_fail++; $display("FAIL convert_overrun: got %0d want 3", ovr_cnt); end
    n_cmp++; if (busy_cnt !== 70) begin n_fail++; $display("FAIL convert_busy_len: got %0d want 70", busy_cnt); end
    n_cmp++; if (rd_word !== 16'h1234) begin n_fail++; $display("FAIL convert_data: got %h want 1234", rd_word); end
    n_cmp++; if (cfg_o !== 6'b010011) begin n_fail++; $display("FAIL convert_cfg: got %b want 010011", cfg_o); end
  endtask

  task automatic test_abort_shift();
    @(negedge s_clk);
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(16'h5555);
    #900;
    sck_cycles(0, 8, 6'b010011);
    #100;
    n_cmp++; if (rd_word[7:0] !== 8'h55) begin n_fail++; $display("FAIL abort_partial_data: got %h want 55", rd_word[7:0]); end
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(16'h0001);
    #900;
    n_cmp++; if (ovr_cnt !== 1 || done_cnt !== 0) begin
      n_fail++; $display("FAIL abort_overrun: got ovr=%0d done=%0d want 1/0", ovr_cnt, done_cnt); end
    n_cmp++; if (busy_cnt !== 70) begin n_fail++; $display("FAIL abort_busy_len: got %0d want 70", busy_cnt); end
    sck_cycles(0, 16, 6'b010011);
    #100;
    n_cmp++; if (rd_word !== 16'h0001) begin n_fail++; $display("FAIL abort_next_data: got %h want 0001", rd_word); end
    n_cmp++; if (cfg_o !== 6'b010011 || done_cnt !== 1) begin
      n_fail++; $display("FAIL abort_next_cfg: got cfg=%b done=%0d want 010011/1", cfg_o, done_cnt); end
  endtask

  task automatic test_partial_cfg();
    @(negedge s_clk);
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(16'hAAAA);
    #900;
    sck_cycles(0, 3, 6'b111111);
    #100;
    cnv_pulse(16'h0F0F);
    #100;
    n_cmp++; if (cfg_o !== 6'b010011 || cfgv_cnt !== 0) begin
      n_fail++; $display("FAIL partial_cfg: got cfg=%b valid=%0d want 010011/0", cfg_o, cfgv_cnt); end
    n_cmp++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL partial_overrun: got %0d want 1", ovr_cnt); end
    reset_dut();
  endtask

  task automatic test_back_to_back();
    run_frame(16'hFFFF, 6'b000000);
    n_cmp++; if (rd_word !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_ffff: got %h want ffff", rd_word); end
    n_cmp++; if (adc_bus.ADC_SDO !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_ffff_end: got sdo=%b done=%0d want 0/1", adc_bus.ADC_SDO, done_cnt); end
    run_frame(16'h0000, 6'b000000);
    n_cmp++; if (rd_word !== 16'h0000) begin n_fail++; $display("FAIL b2b_0000: got %h want 0000", rd_word); end
    n_cmp++; if (adc_bus.ADC_SDO !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_0000_end: got sdo=%b done=%0d want 0/1", adc_bus.ADC_SDO, done_cnt); end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge s_clk);
    clear_counts();
    rd_word = 16'h0000;
    cnv_pulse(16'hFFFF);
    #900;
    sck_cycles(0, 8, 6'b111111);
    #50;
    n_cmp++; if (cfg_o !== 6'b111111 || adc_bus.ADC_SDO !== 1'b1) begin
      n_fail++; $display("FAIL mid_shift_pre: got cfg=%b sdo=%b want 111111/1", cfg_o, adc_bus.ADC_SDO); end
    @(negedge s_clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({adc_bus.ADC_SDO, busy_o, cfg_o, cfg_valid_o, frame_done_o, overrun_o} !== 11'b0) begin
      n_fail++; $display("FAIL async_reset: got sdo=%b busy=%b cfg=%b pulses=%b want all 0",
                         adc_bus.ADC_SDO, busy_o, cfg_o, {cfg_valid_o, frame_done_o, overrun_o}); end
    #20;
    reset = 1'b0;
    @(negedge s_clk);
    clear_counts();
    sck_cycles(8, 2, 6'b000000);
    #100;
    n_cmp++; if (ovr_cnt !== 0 || done_cnt !== 0 || busy_cnt !== 0) begin
      n_fail++; $display("FAIL idle_after_reset: got ovr=%0d done=%0d busy=%0d want 0/0/0", ovr_cnt, done_cnt, busy_cnt); end
    run_frame(16'hC001, 6'b000000);
    n_cmp++; if (rd_word !== 16'hC001 || done_cnt !== 1) begin
      n_fail++; $display("FAIL post_reset_frame: got %h done=%0d want c001/1", rd_word, done_cnt); end
  endtask

  initial begin
    clear_counts();
    rd_word = 16'h0000;
    test_reset();
    test_single_frame();
    test_cfg_capture();
    test_overrun_convert();
    test_abort_shift();
    test_partial_cfg();
    test_back_to_back();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
